// File: rtl/user_pwm_bank_if.sv
// APB4 register bus and user GPIO pin bundle shared by user-slot IPs.
// apb4_if carries 32-bit address/data; user_gpio_if is sized by GPIO_W.
interface apb4_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

interface user_gpio_if #(
    parameter int unsigned GPIO_W = 16
);
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_oe;

    modport dut (input gpio_in, output gpio_out, gpio_oe);
    modport pad (output gpio_in, input gpio_out, gpio_oe);
endinterface

// File: rtl/user_pwm_bank.sv
// APB4 user IP: CH_NUM edge-aligned PWM channels on a shared prescaler/counter.
// Define USER_PWM_SHADOW_EN to buffer PERIOD/DUTY writes until the counter wraps.
module user_pwm_bank #(
    parameter logic [7:0]  ID     = 8'd255,
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned GPIO_W = 16
) (
    input logic      clk_i,
    input logic      rst_n_i,
    user_gpio_if.dut gpio,
    apb4_if.slave    apb
);
    localparam logic [7:0] A_ID     = 8'h00;
    localparam logic [7:0] A_CTRL   = 8'h04;
    localparam logic [7:0] A_PSCR   = 8'h08;
    localparam logic [7:0] A_PERIOD = 8'h0C;
    localparam logic [7:0] A_CHEN   = 8'h10;
    localparam logic [7:0] A_POL    = 8'h14;
    localparam logic [7:0] A_CNT    = 8'h18;
    localparam logic [7:0] A_DUTY0  = 8'h20;

    logic [7:0]        addr;
    logic              wr_en;
    logic              rd_en;
    logic [CNT_W-1:0]  wdata_cnt;
    logic              en;
    logic              clr;
    logic              wr_pscr;
    logic              wr_period;
    logic [15:0]       pscr;
    logic [15:0]       psc_cnt;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  period_rd;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  duty    [CH_NUM];
    logic [CNT_W-1:0]  duty_rd [CH_NUM];
    logic [CH_NUM-1:0] chen;
    logic [CH_NUM-1:0] pol;
    logic [5:0]        duty_idx;
    logic [CH_NUM-1:0] duty_hit;
    logic [CH_NUM-1:0] duty_wr;
    logic              tick;
    logic              wrap;
    logic [31:0]       rdata;
    logic [GPIO_W-1:0] out_d;
    logic [GPIO_W-1:0] oe_d;
    logic [GPIO_W-1:0] out_q;
    logic [GPIO_W-1:0] oe_q;
    logic              unused_ok;

    assign addr      = apb.paddr[7:0];
    assign wr_en     = apb.psel & apb.penable & apb.pwrite;
    assign rd_en     = apb.psel & apb.penable & ~apb.pwrite;
    assign wdata_cnt = apb.pwdata[CNT_W-1:0];
    assign clr       = wr_en && (addr == A_CTRL) && apb.pwdata[1];
    assign wr_pscr   = wr_en && (addr == A_PSCR);
    assign wr_period = wr_en && (addr == A_PERIOD);
    assign tick      = en && (psc_cnt == pscr);
    assign wrap      = tick && (cnt >= period);
    assign duty_idx  = addr[7:2] - 6'd8;

    always_comb begin
        duty_hit = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            duty_hit[i] = (addr >= A_DUTY0) && (addr[1:0] == 2'b00) && (duty_idx == 6'(i));
        end
        duty_wr = duty_hit & {CH_NUM{wr_en}};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en   <= 1'b0;
            pscr <= '0;
            chen <= '0;
            pol  <= '0;
        end else if (wr_en) begin
            case (addr)
                A_CTRL:  en   <= apb.pwdata[0];
                A_PSCR:  pscr <= apb.pwdata[15:0];
                A_CHEN:  chen <= apb.pwdata[CH_NUM-1:0];
                A_POL:   pol  <= apb.pwdata[CH_NUM-1:0];
                default: ;
            endcase
        end
    end

    // CLR wins over a coincident tick; a PSCR write restarts the prescale interval.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            psc_cnt <= '0;
            cnt     <= '0;
        end else begin
            if (clr || wr_pscr || tick) begin
                psc_cnt <= '0;
            end else if (en) begin
                psc_cnt <= psc_cnt + 16'd1;
            end
            if (clr || wrap) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef USER_PWM_SHADOW_EN
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh [CH_NUM];
    logic             load;

    assign load = !en || wrap;

    // A write landing on a load edge bypasses the shadow so it is not lost.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            period_sh <= '0;
            period    <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                duty_sh[i] <= '0;
                duty[i]    <= '0;
            end
        end else begin
            if (wr_period) period_sh <= wdata_cnt;
            if (load)      period    <= wr_period ? wdata_cnt : period_sh;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (duty_wr[i]) duty_sh[i] <= wdata_cnt;
                if (load)       duty[i]    <= duty_wr[i] ? wdata_cnt : duty_sh[i];
            end
        end
    end

    assign period_rd = period_sh;
    assign duty_rd   = duty_sh;
`else
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            period <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                duty[i] <= '0;
            end
        end else begin
            if (wr_period) period <= wdata_cnt;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (duty_wr[i]) duty[i] <= wdata_cnt;
            end
        end
    end

    assign period_rd = period;
    assign duty_rd   = duty;
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            A_ID:     rdata[7:0]        = ID;
            A_CTRL:   rdata[0]          = en;
            A_PSCR:   rdata[15:0]       = pscr;
            A_PERIOD: rdata[CNT_W-1:0]  = period_rd;
            A_CHEN:   rdata[CH_NUM-1:0] = chen;
            A_POL:    rdata[CH_NUM-1:0] = pol;
            A_CNT:    rdata[CNT_W-1:0]  = cnt;
            default: begin
                for (int unsigned i = 0; i < CH_NUM; i++) begin
                    if (duty_hit[i]) rdata[CNT_W-1:0] = duty_rd[i];
                end
            end
        endcase
    end

    always_comb begin
        out_d = '0;
        oe_d  = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            out_d[i] = en ? ((cnt < duty[i]) ^ pol[i]) : pol[i];
        end
        oe_d[CH_NUM-1:0] = chen;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_q <= '0;
            oe_q  <= '0;
        end else begin
            out_q <= out_d;
            oe_q  <= oe_d;
        end
    end

    assign gpio.gpio_out = out_q;
    assign gpio.gpio_oe  = oe_q;
    assign apb.prdata    = rd_en ? rdata : '0;
    assign apb.pready    = 1'b1;
    assign apb.pslverr   = 1'b0;

    assign unused_ok = &{1'b0, apb.paddr[31:8], apb.pwdata, apb.pstrb, apb.pprot, gpio.gpio_in, 1'b0};
endmodule

// File: tb/tb_user_pwm_bank.sv
// Directed bench for user_pwm_bank: expected values queued on stimulus, popped on DUT output.
// Shadow-mode expectations follow USER_PWM_SHADOW_EN.
module tb_user_pwm_bank;
    localparam int unsigned CH = 4;
    localparam int unsigned GW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb4_if apb();
    user_gpio_if #(.GPIO_W(GW)) gpio();

    user_pwm_bank #(.ID(8'h5A), .CH_NUM(CH), .CNT_W(16), .GPIO_W(GW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .gpio    (gpio),
        .apb     (apb)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] duty_m [CH];
    logic [3:0]  pol_m;
    logic [31:0] rd;

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow: observed %h with nothing expected", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
        apb.paddr = {24'h0, a}; apb.pwdata = d;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0;
        apb.paddr = {24'h0, a};
        @(posedge clk); #1;
        apb.penable = 1'b1;
        #1 d = apb.prdata;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        sb_push(tag, exp);
        apb_read(a, d);
        sb_check(d);
    endtask

    function automatic int cnt_at(input int j, input int p, input int per);
        return (j / (p + 1)) % (per + 1);
    endfunction

    // Pin k cycles after the enabling edge reflects the counter one cycle earlier.
    function automatic logic [15:0] exp_pins(input int k, input int p, input int per);
        logic [15:0] v;
        v = '0;
        if (k == 0) begin
            v[3:0] = pol_m;
        end else begin
            for (int i = 0; i < CH; i++) begin
                v[i] = (cnt_at(k - 1, p, per) < int'(duty_m[i])) ^ pol_m[i];
            end
        end
        return v;
    endfunction

    task automatic run_pwm(input int p, input int per, input int n, input logic [31:0] ctrl);
        apb_write(8'h04, ctrl);
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b1; apb.paddr = 32'h18;
        #1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #2;
            end
            sb_push($sformatf("pins p=%0d k=%0d", p, k), {16'h0, exp_pins(k, p, per)});
            sb_check({16'h0, gpio.gpio_out});
            sb_push($sformatf("cnt p=%0d k=%0d", p, k), 32'(cnt_at(k, p, per)));
            sb_check(apb.prdata);
        end
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sw_k;
        logic [7:0] reg_addrs [6];
        reg_addrs = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0; apb.pstrb = 4'hF; apb.pprot = '0;
        gpio.gpio_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        sb_push("gpio_out_rst", 32'h0); sb_check({16'h0, gpio.gpio_out});
        sb_push("gpio_oe_rst", 32'h0);  sb_check({16'h0, gpio.gpio_oe});
        sb_push("prdata_idle", 32'h0);  sb_check(apb.prdata);
        sb_push("pready", 32'h1);       sb_check({31'h0, apb.pready});
        sb_push("pslverr", 32'h0);      sb_check({31'h0, apb.pslverr});
        rd_check("id", 8'h00, 32'h0000_005A);
        foreach (reg_addrs[i]) rd_check($sformatf("rst_reg_%h", reg_addrs[i]), reg_addrs[i], 32'h0);
        rd_check("unmapped_1c", 8'h1C, 32'h0);

        // Field truncation and write-only CLR
        apb_write(8'h10, 32'hFFFF_FFFF);
        rd_check("chen_trunc", 8'h10, 32'h0000_000F);
        apb_write(8'h08, 32'h0001_2345);
        rd_check("pscr_trunc", 8'h08, 32'h0000_2345);
        apb_write(8'h04, 32'h2);
        rd_check("ctrl_clr_reads0", 8'h04, 32'h0);
        apb_write(8'h3C, 32'h1234);
        rd_check("unmapped_3c", 8'h3C, 32'h0);

        // PSCR=0, PERIOD=9, DUTY0=3
        apb_write(8'h08, 32'h0);
        apb_write(8'h0C, 32'h9);
        apb_write(8'h20, 32'h3);
        apb_write(8'h10, 32'h1);
        rd_check("period_rb", 8'h0C, 32'h9);
        rd_check("duty0_rb", 8'h20, 32'h3);
        duty_m = '{16'd3, 16'd0, 16'd0, 16'd0};
        pol_m = 4'b0000;
        run_pwm(0, 9, 30, 32'h3);
        sb_push("oe_chen1", 32'h1); sb_check({16'h0, gpio.gpio_oe});

        // PSCR=1: period doubles, CNT steps every two cycles
        apb_write(8'h04, 32'h0);
        apb_write(8'h08, 32'h1);
        run_pwm(1, 9, 45, 32'h3);

        // Boundary duties with polarity
        apb_write(8'h04, 32'h0);
        apb_write(8'h08, 32'h0);
        apb_write(8'h24, 32'h0);
        apb_write(8'h28, 32'd12);
        apb_write(8'h14, 32'h2);
        apb_write(8'h10, 32'h7);
        duty_m[1] = 16'd0;
        duty_m[2] = 16'd12;
        pol_m = 4'b0010;
        run_pwm(0, 9, 25, 32'h3);
        sb_push("oe_chen7", 32'h7); sb_check({16'h0, gpio.gpio_oe});

        // Disable and clear mid-period, then restart without CLR
        apb_write(8'h04, 32'h0);
        apb_write(8'h04, 32'h2);
        rd_check("cnt_after_clr", 8'h18, 32'h0);
        sb_push("pins_at_pol", 32'h2); sb_check({16'h0, gpio.gpio_out});
        rd_check("ctrl_en0", 8'h04, 32'h0);
        run_pwm(0, 9, 15, 32'h1);

        // DUTY0 3 -> 7 committed at CNT=5
        apb_write(8'h04, 32'h0);
        apb_write(8'h14, 32'h0);
        apb_write(8'h10, 32'h1);
        apb_write(8'h20, 32'h3);
`ifdef USER_PWM_SHADOW_EN
        sw_k = 11;
`else
        sw_k = 6;
`endif
        apb_write(8'h04, 32'h3);
        #1;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) begin
                @(posedge clk); #2;
            end
            sb_push($sformatf("duty_upd k=%0d", k),
                    (k == 0) ? 32'h0 : 32'(cnt_at(k - 1, 0, 9) < ((k >= sw_k) ? 7 : 3)));
            sb_check({31'h0, gpio.gpio_out[0]});
            if (k == 3) begin
                apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
                apb.paddr = 32'h20; apb.pwdata = 32'h7;
            end else if (k == 4) begin
                apb.penable = 1'b1;
            end else if (k == 5) begin
                apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
            end
        end
        rd_check("duty0_new", 8'h20, 32'h7);

        // Reset asserted while running
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb_push("out_midrst", 32'h0); sb_check({16'h0, gpio.gpio_out});
        sb_push("oe_midrst", 32'h0);  sb_check({16'h0, gpio.gpio_oe});
        rst_n = 1'b1;
        rd_check("cnt_after_rst", 8'h18, 32'h0);
        rd_check("period_after_rst", 8'h0C, 32'h0);
        rd_check("duty0_after_rst", 8'h20, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
